// File: rtl/drum_column_sequencer.sv
// Column sequencer for the drum-mesh finite-difference update.
// Loads and walks the u_n / u_n-1 banks and feeds the compute datapath.
module drum_column_sequencer #(
    parameter int ROWS      = 30,
    parameter int ADDR_W    = 5,
    parameter int AUDIO_ROW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic [17:0]       init_data,
    output logic [ADDR_W-1:0] init_addr,
    input  logic              step_start,
    output logic              step_done,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] un_raddr,
    output logic [ADDR_W-1:0] un_waddr,
    output logic [ADDR_W-1:0] unm1_raddr,
    output logic [ADDR_W-1:0] unm1_waddr,
    output logic              un_we,
    output logic              unm1_we,
    output logic [17:0]       un_d,
    output logic [17:0]       unm1_d,
    input  logic [17:0]       un_q,
    input  logic [17:0]       unm1_q,
    output logic [17:0]       cu_center,
    output logic [17:0]       cu_up,
    output logic [17:0]       cu_down,
    output logic [17:0]       cu_prev,
    output logic              cu_valid,
    output logic [ADDR_W-1:0] cu_row,
    input  logic [17:0]       cu_result,
    output logic [17:0]       audio_sample,
    output logic [15:0]       step_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_READY,
        S_PRIME,
        S_PWAIT,
        S_RD,
        S_WT,
        S_CMP,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] AUD  = ADDR_W'(AUDIO_ROW);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [17:0]       center_q, center_d;
    logic [17:0]       up_q, up_d;
    logic [17:0]       down_q, down_d;
    logic [17:0]       prev_q, prev_d;
    logic [17:0]       result_q, result_d;
    logic [17:0]       audio_q, audio_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W-1:0] rd_next;

    // The up-neighbour read clamps at the last row; its data is zeroed later.
    assign rd_next = (row_q == LAST) ? LAST : row_q + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            center_q <= '0;
            up_q     <= '0;
            down_q   <= '0;
            prev_q   <= '0;
            result_q <= '0;
            audio_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            center_q <= center_d;
            up_q     <= up_d;
            down_q   <= down_d;
            prev_q   <= prev_d;
            result_q <= result_d;
            audio_q  <= audio_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        center_d   = center_q;
        up_d       = up_q;
        down_d     = down_q;
        prev_d     = prev_q;
        result_d   = result_q;
        audio_d    = audio_q;
        count_d    = count_q;
        init_addr  = '0;
        un_raddr   = '0;
        unm1_raddr = '0;
        un_waddr   = '0;
        unm1_waddr = '0;
        un_we      = 1'b0;
        unm1_we    = 1'b0;
        un_d       = '0;
        unm1_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    state_d = S_INIT;
                    row_d   = '0;
                end
            end
            S_INIT: begin
                init_addr  = row_q;
                un_waddr   = row_q;
                unm1_waddr = row_q;
                un_we      = 1'b1;
                unm1_we    = 1'b1;
                un_d       = init_data;
                unm1_d     = init_data;
                if (row_q == LAST) begin
                    state_d = S_READY;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ONE;
                end
            end
            S_READY: begin
                if (init_start) begin
                    state_d = S_INIT;
                    row_d   = '0;
                end else if (step_start) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                un_raddr = '0;
                row_d    = '0;
                state_d  = S_PWAIT;
            end
            S_PWAIT: begin
                center_d = un_q;
                down_d   = '0;
                row_d    = '0;
                state_d  = S_RD;
            end
            S_RD: begin
                un_raddr   = rd_next;
                unm1_raddr = row_q;
                state_d    = S_WT;
            end
            S_WT: begin
                un_raddr   = rd_next;
                unm1_raddr = row_q;
                up_d       = (row_q == LAST) ? '0 : un_q;
                prev_d     = unm1_q;
                state_d    = S_CMP;
            end
            S_CMP: begin
                un_raddr   = rd_next;
                unm1_raddr = row_q;
                result_d   = cu_result;
                state_d    = S_WB;
            end
            S_WB: begin
                un_waddr   = row_q;
                unm1_waddr = row_q;
                un_we      = 1'b1;
                unm1_we    = 1'b1;
                un_d       = result_q;
                unm1_d     = center_q;
                if (row_q == AUD) begin
                    audio_d = result_q;
                end
                down_d   = center_q;
                center_d = up_q;
                if (row_q == LAST) begin
                    row_d   = '0;
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + ONE;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                count_d = count_q + 16'd1;
                state_d = S_READY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready        = (state_q == S_READY);
    assign busy         = (state_q != S_IDLE) && (state_q != S_READY);
    assign step_done    = (state_q == S_DONE);
    assign cu_valid     = (state_q == S_CMP);
    assign cu_row       = row_q;
    assign cu_center    = center_q;
    assign cu_up        = up_q;
    assign cu_down      = down_q;
    assign cu_prev      = prev_q;
    assign audio_sample = audio_q;
    assign step_count   = count_q;

endmodule
